param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
Parametrised successor to the fixed 8-bit enable-divider plus up/down counter pair that drives the board LEDs. It integrates the prescaler, a synchronised direction key, a synchronous load, programmable bounds and three count modes (wrap, saturate, bounce). It also provides tick, terminal-count and direction outputs. It sits between the board clock/keys and the LED output register in top-level designs.

Parameters:
WIDTH, 8, counter and load width in bits.
DIV, 5000000, prescaler ratio: one count step every DIV enabled clocks. Must be at least 1.
MIN_VAL, 0, lower count bound.
MAX_VAL, 255, upper count bound. Requires MIN_VAL < MAX_VAL <= 2^WIDTH-1.
MODE, 0, boundary behaviour: 0 = wrap, 1 = saturate, 2 = bounce (ping-pong).

Ports:
clock_5  in  1  single system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-low reset.
en  in  1  run enable; 0 freezes both the prescaler and the count.
up_down  in  1  raw key input, asynchronous; 1 = count up, 0 = count down. Ignored in MODE 2.
load  in  1  synchronous load strobe.
load_val  in  WIDTH  value to load.
count_out  out  WIDTH  registered count value.
tick  out  1  one-cycle pulse on each prescaler terminal cycle.
tc  out  1  one-cycle terminal-count pulse.
dir_out  out  1  effective direction; 1 = up.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-count):
  - prescaler=0, count_out=MIN_VAL, tick=0, tc=0.
  - Bounce direction register = up.
  - Both up_down synchroniser flops = 1.
- Direction sync: 2-FF synchroniser on up_down. The effective direction follows a key change after 2 clock_5 edges.
- Prescaler:
  - While en=1, counts 0..DIV-1. On the edge where prescaler==DIV-1 it returns to 0 and tick=1 for the following cycle.
  - While en=0, the prescaler holds its value and tick=0.
  - DIV=1: tick is high every cycle that en is high.
- Count update: happens only on the edge that asserts tick. The new count_out and tc are visible in the same cycle as tick, one clock after the terminal prescaler cycle.
- Load:
  - load=1 has priority over tick and over en.
  - count_out <= clamp(load_val, MIN_VAL, MAX_VAL) on the next edge; prescaler <= 0; tick=0; tc=0.
  - The bounce direction register is unchanged.
- MODE 0 (wrap):
  - Up at MAX_VAL gives MIN_VAL with tc=1.
  - Down at MIN_VAL gives MAX_VAL with tc=1.
  - Otherwise the count steps by ±1 and tc=0.
- MODE 1 (saturate):
  - Up at MAX_VAL holds MAX_VAL with tc=1.
  - Down at MIN_VAL holds MIN_VAL with tc=1.
  - tc repeats on every tick while the count is blocked at a bound.
- MODE 2 (bounce):
  - Up at MAX_VAL gives MAX_VAL-1, direction register becomes down, tc=1.
  - Down at MIN_VAL gives MIN_VAL+1, direction register becomes up, tc=1.
  - The synchronised up_down is ignored.
- dir_out:
  - MODE 0/1: synchronised up_down.
  - MODE 2: direction register, updated in the same cycle as count_out.
- A direction change arriving on the same edge as a tick uses the pre-change synchronised value for that step.
- tick and tc are always exactly one cycle wide. There are no combinational paths from inputs to outputs.

Test Plan:
Bench parameters throughout: WIDTH=4, DIV=4, MIN_VAL=2, MAX_VAL=9.

- Reset then en=1, up_down=1, MODE=0 -> count_out=2 after reset. tick on cycles 4, 8, 12, ...; count_out 3, 4, 5, ... 9, then 2 with tc=1 on that tick only.
- MODE=0, up_down=0 from count 2 -> next tick gives 9 with tc=1. Toggling up_down shows dir_out changing after 2 edges.
- MODE=1, up_down=1, load_val=8 -> 9 then 9, 9 with tc=1 on every tick at the bound. up_down=0 -> 8, 7.
- MODE=2 from 8, up_down forced 0 -> 9 (tc=0), 8 (tc=1, dir_out=0), 7, ... 2, then 3 (tc=1, dir_out=1).
- load=1 with load_val=15 on a tick cycle -> count_out=9, no tc, prescaler restarts, next tick 4 cycles later. load_val=0 -> 2.
- en=0 mid-prescale at value 2 for 10 cycles -> no tick, count frozen. en=1 -> tick after 2 cycles. reset pulse mid-run -> count_out=2 immediately, tick=0, tc=0.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parametrised prescaled up/down counter with synchronised direction key,
// clamped synchronous load, programmable bounds and wrap/saturate/bounce modes.
module param_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int DIV     = 5000000,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 255,
  parameter int MODE    = 0
) (
  input  logic             clock_5,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             tick,
  output logic             tc,
  output logic             dir_out
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic signed [WIDTH:0] MIN_S = signed'({1'b0, MIN_V});
  localparam logic signed [WIDTH:0] MAX_S = signed'({1'b0, MAX_V});

  if (DIV < 1 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > (2 ** WIDTH) - 1 ||
      MODE < 0 || MODE > 2) begin : g_bad_params
    $error("param_updown_counter: illegal parameter combination");
  end

  // Bounds compared as zero-extended signed values so a zero MIN_VAL is not a
  // constant unsigned comparison.
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    logic signed [WIDTH:0] vs;
    vs = signed'({1'b0, v});
    if (vs < MIN_S)
      clamp = MIN_V;
    else if (vs > MAX_S)
      clamp = MAX_V;
    else
      clamp = v;
  endfunction

  logic                  key_p0;
  logic                  key_p1;
  logic [PRE_W-1:0]      prescale;
  logic                  dir_reg;
  logic                  dir_eff;
  logic signed [WIDTH:0] cnt_s;
  logic [WIDTH-1:0]      next_cnt;
  logic                  next_tc;
  logic                  next_dir;

  // Stage p0/p1: two-flop synchroniser for the asynchronous direction key
  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= up_down;
      key_p1 <= key_p0;
    end
  end

  assign dir_eff = (MODE == 2) ? dir_reg : key_p1;
  assign dir_out = dir_eff;

  // Next count, terminal flag and bounce direction for the coming tick
  always_comb begin
    cnt_s    = signed'({1'b0, count_out});
    next_cnt = count_out;
    next_tc  = 1'b0;
    next_dir = dir_reg;
    if (dir_eff) begin
      if (cnt_s >= MAX_S) begin
        next_tc = 1'b1;
        if (MODE == 0) begin
          next_cnt = MIN_V;
        end else if (MODE == 2) begin
          next_cnt = MAX_V - 1'b1;
          next_dir = 1'b0;
        end
      end else begin
        next_cnt = count_out + 1'b1;
      end
    end else begin
      if (cnt_s <= MIN_S) begin
        next_tc = 1'b1;
        if (MODE == 0) begin
          next_cnt = MAX_V;
        end else if (MODE == 2) begin
          next_cnt = MIN_V + 1'b1;
          next_dir = 1'b1;
        end
      end else begin
        next_cnt = count_out - 1'b1;
      end
    end
  end

  // Prescaler and count register; load overrides both tick and enable
  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      prescale  <= '0;
      count_out <= MIN_V;
      tick      <= 1'b0;
      tc        <= 1'b0;
      dir_reg   <= 1'b1;
    end else if (load) begin
      prescale  <= '0;
      count_out <= clamp(load_val);
      tick      <= 1'b0;
      tc        <= 1'b0;
    end else if (en && prescale == PRE_LAST) begin
      prescale  <= '0;
      count_out <= next_cnt;
      tick      <= 1'b1;
      tc        <= next_tc;
      dir_reg   <= next_dir;
    end else begin
      if (en)
        prescale <= prescale + 1'b1;
      tick <= 1'b0;
      tc   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: one instance per mode sharing stimulus,
// expected tick results queued per scenario and compared as each tick arrives.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up_down = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] cnt0, cnt1, cnt2;
  logic       tk0, tk1, tk2, tc0, tc1, tc2, dr0, dr1, dr2;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .DIV(4), .MIN_VAL(2), .MAX_VAL(9), .MODE(0)) u_wrap (
    .clock_5(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .count_out(cnt0), .tick(tk0), .tc(tc0), .dir_out(dr0));
  param_updown_counter #(.WIDTH(4), .DIV(4), .MIN_VAL(2), .MAX_VAL(9), .MODE(1)) u_sat (
    .clock_5(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .count_out(cnt1), .tick(tk1), .tc(tc1), .dir_out(dr1));
  param_updown_counter #(.WIDTH(4), .DIV(4), .MIN_VAL(2), .MAX_VAL(9), .MODE(2)) u_bnc (
    .clock_5(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .count_out(cnt2), .tick(tk2), .tc(tc2), .dir_out(dr2));

  typedef struct packed {
    logic       tk;
    logic       tc;
    logic       dir;
    logic [3:0] cnt;
  } obs_t;

  typedef struct {
    logic [3:0] cnt;
    logic       tc;
    logic       dir;
    int         gap;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic obs_t get_obs(input int m);
    obs_t o;
    case (m)
      0:       o = '{tk: tk0, tc: tc0, dir: dr0, cnt: cnt0};
      1:       o = '{tk: tk1, tc: tc1, dir: dr1, cnt: cnt1};
      default: o = '{tk: tk2, tc: tc2, dir: dr2, cnt: cnt2};
    endcase
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c, input logic t, input logic d, input int g);
    exp_t e;
    e.cnt = c; e.tc = t; e.dir = d; e.gap = g;
    sbq.push_back(e);
  endtask

  // Advances until the selected instance shows tick; n = edges taken.
  task automatic wait_tick(input int m, output int n);
    obs_t o;
    bit   seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      step();
      n++;
      o = get_obs(m);
      if (o.tk === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout mode%0d: no tick within %0d cycles, required one", m, n);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    #1 reset = 1'b0;
    step();
    step();
    for (int m = 0; m < 3; m++) begin
      o = get_obs(m);
      n_checks++;
      if (o.cnt !== 4'd2) begin
        n_fail++; $display("FAIL reset_count mode%0d: got %0d required 2", m, o.cnt);
      end
      n_checks++;
      if (o.tk !== 1'b0 || o.tc !== 1'b0) begin
        n_fail++; $display("FAIL reset_flags mode%0d: tick=%b tc=%b required 0 0", m, o.tk, o.tc);
      end
      n_checks++;
      if (o.dir !== 1'b1) begin
        n_fail++; $display("FAIL reset_dir mode%0d: got %b required 1", m, o.dir);
      end
    end
  endtask

  task automatic test_wrap_up();
    exp_t e;
    obs_t o;
    int   n;
    reset = 1'b1;
    en = 1'b1;
    up_down = 1'b1;
    for (int v = 3; v <= 9; v++) push(4'(v), 1'b0, 1'b1, 4);
    push(4'd2, 1'b1, 1'b1, 4);
    push(4'd3, 1'b0, 1'b1, 4);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_tick(0, n);
      o = get_obs(0);
      n_checks++;
      if (o.cnt !== e.cnt) begin
        n_fail++; $display("FAIL wrap_up_count: got %0d required %0d", o.cnt, e.cnt);
      end
      n_checks++;
      if (o.tc !== e.tc) begin
        n_fail++; $display("FAIL wrap_up_tc at %0d: got %b required %b", e.cnt, o.tc, e.tc);
      end
      n_checks++;
      if (n != e.gap) begin
        n_fail++; $display("FAIL wrap_up_gap: got %0d cycles required %0d", n, e.gap);
      end
    end
  endtask

  task automatic test_wrap_down();
    exp_t e;
    obs_t o;
    int   n;
    load = 1'b1;
    load_val = 4'd2;
    step();
    load = 1'b0;
    o = get_obs(0);
    n_checks++;
    if (o.cnt !== 4'd2 || o.tk !== 1'b0) begin
      n_fail++; $display("FAIL wrap_load2: count=%0d tick=%b required 2 0", o.cnt, o.tk);
    end
    up_down = 1'b0;
    step();
    n_checks++;
    if (dr0 !== 1'b1) begin
      n_fail++; $display("FAIL dir_sync_1edge_fall: got %b required 1", dr0);
    end
    step();
    n_checks++;
    if (dr0 !== 1'b0) begin
      n_fail++; $display("FAIL dir_sync_2edge_fall: got %b required 0", dr0);
    end
    push(4'd9, 1'b1, 1'b0, 0);
    push(4'd8, 1'b0, 1'b0, 4);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_tick(0, n);
      o = get_obs(0);
      n_checks++;
      if (o.cnt !== e.cnt || o.tc !== e.tc || o.dir !== e.dir) begin
        n_fail++;
        $display("FAIL wrap_down: count=%0d tc=%b dir=%b required %0d %b %b",
                 o.cnt, o.tc, o.dir, e.cnt, e.tc, e.dir);
      end
      n_checks++;
      if (e.gap != 0 && n != e.gap) begin
        n_fail++; $display("FAIL wrap_down_gap: got %0d required %0d", n, e.gap);
      end
    end
    up_down = 1'b1;
    step();
    n_checks++;
    if (dr0 !== 1'b0) begin
      n_fail++; $display("FAIL dir_sync_1edge_rise: got %b required 0", dr0);
    end
    step();
    n_checks++;
    if (dr0 !== 1'b1) begin
      n_fail++; $display("FAIL dir_sync_2edge_rise: got %b required 1", dr0);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    obs_t o;
    int   n;
    int   idx;
    load = 1'b1;
    load_val = 4'd8;
    step();
    load = 1'b0;
    n_checks++;
    if (cnt1 !== 4'd8 || tc1 !== 1'b0) begin
      n_fail++; $display("FAIL sat_load8: count=%0d tc=%b required 8 0", cnt1, tc1);
    end
    push(4'd9, 1'b0, 1'b1, 4);
    push(4'd9, 1'b1, 1'b1, 4);
    push(4'd9, 1'b1, 1'b1, 4);
    push(4'd8, 1'b0, 1'b0, 4);
    push(4'd7, 1'b0, 1'b0, 4);
    idx = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_tick(1, n);
      o = get_obs(1);
      n_checks++;
      if (o.cnt !== e.cnt || o.tc !== e.tc || o.dir !== e.dir) begin
        n_fail++;
        $display("FAIL saturate step%0d: count=%0d tc=%b dir=%b required %0d %b %b",
                 idx, o.cnt, o.tc, o.dir, e.cnt, e.tc, e.dir);
      end
      n_checks++;
      if (n != e.gap) begin
        n_fail++; $display("FAIL saturate_gap step%0d: got %0d required %0d", idx, n, e.gap);
      end
      if (idx == 2) up_down = 1'b0;
      idx++;
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    obs_t o;
    int   n;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    up_down = 1'b0;
    load = 1'b1;
    load_val = 4'd8;
    step();
    load = 1'b0;
    n_checks++;
    if (cnt2 !== 4'd8 || dr2 !== 1'b1) begin
      n_fail++; $display("FAIL bounce_load8: count=%0d dir=%b required 8 1", cnt2, dr2);
    end
    push(4'd9, 1'b0, 1'b1, 4);
    push(4'd8, 1'b1, 1'b0, 4);
    for (int v = 7; v >= 2; v--) push(4'(v), 1'b0, 1'b0, 4);
    push(4'd3, 1'b1, 1'b1, 4);
    push(4'd4, 1'b0, 1'b1, 4);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_tick(2, n);
      o = get_obs(2);
      n_checks++;
      if (o.cnt !== e.cnt || o.tc !== e.tc || o.dir !== e.dir) begin
        n_fail++;
        $display("FAIL bounce: count=%0d tc=%b dir=%b required %0d %b %b",
                 o.cnt, o.tc, o.dir, e.cnt, e.tc, e.dir);
      end
      n_checks++;
      if (n != e.gap) begin
        n_fail++; $display("FAIL bounce_gap at %0d: got %0d required %0d", e.cnt, n, e.gap);
      end
    end
  endtask

  task automatic test_load_priority();
    exp_t e;
    obs_t o;
    int   n;
    up_down = 1'b1;
    wait_tick(0, n);
    step();
    step();
    step();
    load = 1'b1;
    load_val = 4'd15;
    step();
    load = 1'b0;
    for (int m = 0; m < 3; m++) begin
      o = get_obs(m);
      n_checks++;
      if (o.cnt !== 4'd9 || o.tk !== 1'b0 || o.tc !== 1'b0) begin
        n_fail++;
        $display("FAIL load15_on_tick mode%0d: count=%0d tick=%b tc=%b required 9 0 0",
                 m, o.cnt, o.tk, o.tc);
      end
    end
    push(4'd2, 1'b1, 1'b1, 4);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_tick(0, n);
      o = get_obs(0);
      n_checks++;
      if (o.cnt !== e.cnt || o.tc !== e.tc) begin
        n_fail++; $display("FAIL after_load15: count=%0d tc=%b required %0d %b", o.cnt, o.tc, e.cnt, e.tc);
      end
      n_checks++;
      if (n != e.gap) begin
        n_fail++; $display("FAIL load_restart_gap: got %0d required %0d", n, e.gap);
      end
    end
    en = 1'b0;
    load = 1'b1;
    load_val = 4'd0;
    step();
    load = 1'b0;
    n_checks++;
    if (cnt0 !== 4'd2) begin
      n_fail++; $display("FAIL load0_clamp_en0: got %0d required 2", cnt0);
    end
  endtask

  task automatic test_enable();
    exp_t e;
    obs_t o;
    int   n;
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (tk0 !== 1'b0) begin
        n_fail++; $display("FAIL en0_tick cycle%0d: got %b required 0", i, tk0);
      end
    end
    n_checks++;
    if (cnt0 !== 4'd2) begin
      n_fail++; $display("FAIL en0_frozen: got %0d required 2", cnt0);
    end
    en = 1'b1;
    push(4'd3, 1'b0, 1'b1, 2);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      wait_tick(0, n);
      o = get_obs(0);
      n_checks++;
      if (o.cnt !== e.cnt || o.tc !== e.tc) begin
        n_fail++; $display("FAIL en_resume: count=%0d tc=%b required %0d %b", o.cnt, o.tc, e.cnt, e.tc);
      end
      n_checks++;
      if (n != e.gap) begin
        n_fail++; $display("FAIL en_resume_gap: got %0d required %0d", n, e.gap);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   n;
    wait_tick(0, n);
    n_checks++;
    if (tk0 !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_tick: got %b required 1", tk0);
    end
    #2 reset = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      o = get_obs(m);
      n_checks++;
      if (o.cnt !== 4'd2 || o.tk !== 1'b0 || o.tc !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset mode%0d: count=%0d tick=%b tc=%b required 2 0 0",
                 m, o.cnt, o.tk, o.tc);
      end
    end
    n_checks++;
    if (dr2 !== 1'b1) begin
      n_fail++; $display("FAIL async_reset_bounce_dir: got %b required 1", dr2);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_bounce();
    test_load_priority();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
